// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry
// constants and the bulk-clear state machine encoding.
package regfile_pkg;

    localparam int DEF_N    = 32;
    localparam int DEF_ADDR = 5;
    localparam int DEF_NRD  = 2;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear engine: walks every register address once, one per cycle,
// then signals completion for a single cycle before going idle again.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR = DEF_ADDR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    output logic            clear_start_o,
    output logic            clear_we_o,
    output logic [ADDR-1:0] clear_addr_o,
    output logic            clear_busy_o,
    output logic            clear_done_o
);

    clr_state_e      state_q, state_d;
    logic [ADDR-1:0] cnt_q, cnt_d;

    // Next-state and output decode for the clear sequence.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        clear_start_o = 1'b0;
        clear_we_o    = 1'b0;
        clear_busy_o  = 1'b0;
        clear_done_o  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clear_i) begin
                    state_d       = CLR_CLEAR;
                    cnt_d         = '0;
                    clear_start_o = 1'b1;
                end
            end
            CLR_CLEAR: begin
                clear_busy_o = 1'b1;
                clear_we_o   = 1'b1;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = CLR_DONE;
                end
            end
            CLR_DONE: begin
                clear_busy_o = 1'b1;
                clear_done_o = 1'b1;
                state_d      = CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase
    end

    assign clear_addr_o = cnt_q;

    // State and address counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (!reset) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : regfile_clear_fsm

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard, optional
// write-to-read forwarding and a bulk-clear engine. Register 0 is hardwired
// to zero and can never be marked busy.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ADDR   = DEF_ADDR,
    parameter int NRD    = DEF_NRD,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Reg_Write_i,
    input  logic [ADDR-1:0]     Write_Register_i,
    input  logic [N-1:0]        Write_Data_i,
    input  logic [NRD*ADDR-1:0] Read_Register_i,
    output logic [NRD*N-1:0]    Read_Data_o,
    output logic [NRD-1:0]      Read_Busy_o,
    input  logic                Issue_i,
    input  logic [ADDR-1:0]     Issue_Register_i,
    output logic                Issue_Stall_o,
    input  logic                Clear_i,
    output logic                Clear_Busy_o,
    output logic                Clear_Done_o
);

    localparam int DEPTH = 1 << ADDR;

    logic [N-1:0]     regs_q [DEPTH];
    logic [N-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;

    logic            clr_start;
    logic            clr_we;
    logic [ADDR-1:0] clr_addr;
    logic            clr_busy;
    logic            clr_done;
    logic            wr_ok;
    logic            issue_ok;

    regfile_clear_fsm #(.ADDR(ADDR)) u_clear (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (Clear_i),
        .clear_start_o(clr_start),
        .clear_we_o   (clr_we),
        .clear_addr_o (clr_addr),
        .clear_busy_o (clr_busy),
        .clear_done_o (clr_done)
    );

    assign Clear_Busy_o  = clr_busy;
    assign Clear_Done_o  = clr_done;

    // Writes and issues are locked out while the clear engine owns the array.
    assign Issue_Stall_o = Issue_i & (busy_q[Issue_Register_i] | clr_busy);
    assign wr_ok         = Reg_Write_i & ~clr_busy & (Write_Register_i != '0);
    assign issue_ok      = Issue_i & ~Issue_Stall_o & (Issue_Register_i != '0);

    // Next array and scoreboard contents; a same-cycle issue overrides the
    // busy clear from a write, and starting a clear drops every busy bit.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (clr_we) begin
            regs_d[clr_addr] = '0;
        end
        if (wr_ok) begin
            regs_d[Write_Register_i] = Write_Data_i;
            busy_d[Write_Register_i] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[Issue_Register_i] = 1'b1;
        end
        if (clr_start) begin
            busy_d = '0;
        end
    end

    // Array and scoreboard storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset explicitly because reads must return zero
        // right after reset; this keeps it in flops rather than a RAM macro.
        if (!reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports with optional forwarding of the write data.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR-1:0] rd_addr;
        logic            hit;
        assign rd_addr = Read_Register_i[k*ADDR +: ADDR];
        assign hit     = (BYPASS != 0) && wr_ok && (Write_Register_i == rd_addr);
        assign Read_Data_o[k*N +: N] = hit ? Write_Data_i : regs_q[rd_addr];
        assign Read_Busy_o[k]        = hit ? 1'b0 : busy_q[rd_addr];
    end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: two instances (forwarding on and off)
// share stimulus; a reference model predicts every cycle's outputs into a
// queue that a negedge monitor drains and compares.
module tb_regfile_sb;

    localparam int N       = 32;
    localparam int ADDR    = 5;
    localparam int NRD     = 2;
    localparam int DEPTH   = 32;
    localparam int CLR_LAT = DEPTH + 1;

    typedef struct packed {
        logic [NRD*N-1:0] rd_byp;
        logic [NRD-1:0]   rb_byp;
        logic [NRD*N-1:0] rd_nb;
        logic [NRD-1:0]   rb_nb;
        logic             stall;
        logic             cbusy;
        logic             cdone;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset;
    logic                we;
    logic [ADDR-1:0]     wa;
    logic [N-1:0]        wd;
    logic                issue;
    logic [ADDR-1:0]     ia;
    logic                clr;
    logic [ADDR-1:0]     rd_addr [NRD];
    logic [NRD*ADDR-1:0] rd_bus;

    logic [NRD*N-1:0] rd_byp, rd_nb;
    logic [NRD-1:0]   rb_byp, rb_nb;
    logic             stall_byp, stall_nb;
    logic             cbusy_byp, cbusy_nb;
    logic             cdone_byp, cdone_nb;

    assign rd_bus = {rd_addr[1], rd_addr[0]};

    always #5 clk = ~clk;

    regfile_sb #(.N(N), .ADDR(ADDR), .NRD(NRD), .BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
        .Read_Register_i(rd_bus), .Read_Data_o(rd_byp), .Read_Busy_o(rb_byp),
        .Issue_i(issue), .Issue_Register_i(ia), .Issue_Stall_o(stall_byp),
        .Clear_i(clr), .Clear_Busy_o(cbusy_byp), .Clear_Done_o(cdone_byp)
    );

    regfile_sb #(.N(N), .ADDR(ADDR), .NRD(NRD), .BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
        .Read_Register_i(rd_bus), .Read_Data_o(rd_nb), .Read_Busy_o(rb_nb),
        .Issue_i(issue), .Issue_Register_i(ia), .Issue_Stall_o(stall_nb),
        .Clear_i(clr), .Clear_Busy_o(cbusy_nb), .Clear_Done_o(cdone_nb)
    );

    // Reference model state: plain arrays plus "cycles since clear accepted".
    logic [N-1:0] m_mem  [DEPTH];
    logic         m_busy [DEPTH];
    int           m_age;

    exp_t exp_q[$];
    bit   chk_on = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        logic cb;
        logic hit;
        int   ra;
        cb      = (m_age != 0);
        e       = '0;
        e.cbusy = cb;
        e.cdone = (m_age == CLR_LAT);
        e.stall = issue && (m_busy[ia] || cb);
        for (int p = 0; p < NRD; p++) begin
            ra  = int'(rd_addr[p]);
            hit = we && !cb && (int'(wa) == ra) && (ra != 0);
            e.rd_byp[p*N +: N] = hit ? wd : m_mem[ra];
            e.rb_byp[p]        = hit ? 1'b0 : m_busy[ra];
            e.rd_nb[p*N +: N]  = m_mem[ra];
            e.rb_nb[p]         = m_busy[ra];
        end
        return e;
    endfunction

    task automatic model_update();
        logic stalled;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_age = 0;
        end else if (m_age != 0) begin
            if (m_age <= DEPTH) m_mem[m_age-1] = '0;
            m_age = (m_age == CLR_LAT) ? 0 : m_age + 1;
        end else begin
            stalled = issue && m_busy[ia];
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (issue && !stalled && ia != 0) m_busy[ia] = 1'b1;
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
                m_age = 1;
            end
        end
    endtask

    // One clock: predict this cycle's outputs, then advance the model at the edge.
    task automatic cycle();
        if (chk_on) exp_q.push_back(model_outputs());
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        we = 1'b0; wa = '0; wd = '0;
        issue = 1'b0; ia = '0; clr = 1'b0;
        rd_addr[0] = '0; rd_addr[1] = '0;
    endtask

    task automatic sweep_reads();
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr[0] = 5'(i);
            rd_addr[1] = 5'(DEPTH - 1 - i);
            cycle();
        end
    endtask

    // Monitor: every cycle with a prediction pending, compare all outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rdata_byp", 64'(rd_byp), 64'(e.rd_byp));
            check("rbusy_byp", 64'(rb_byp), 64'(e.rb_byp));
            check("rdata_nobyp", 64'(rd_nb), 64'(e.rd_nb));
            check("rbusy_nobyp", 64'(rb_nb), 64'(e.rb_nb));
            check("issue_stall", 64'({stall_byp, stall_nb}), 64'({e.stall, e.stall}));
            check("clear_busy", 64'({cbusy_byp, cbusy_nb}), 64'({e.cbusy, e.cbusy}));
            check("clear_done", 64'({cdone_byp, cdone_nb}), 64'({e.cdone, e.cdone}));
        end
    end

    initial begin
        int edges;
        reset = 1'b0;
        set_idle();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_age = 0;
        cycle();
        cycle();

        // Reset state, including a write/issue/clear that reset must override.
        chk_on = 1'b1;
        we = 1'b1; wa = 5'd4; wd = 32'h5555_AAAA; issue = 1'b1; ia = 5'd6; clr = 1'b1;
        cycle();
        set_idle();
        rd_addr[0] = 5'd4; rd_addr[1] = 5'd6;
        cycle();
        reset = 1'b1;
        cycle();

        // Fill 1..31 while both ports sweep in opposite directions, then re-read.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1'b1; wa = 5'(i); wd = $urandom;
            rd_addr[0] = 5'(i); rd_addr[1] = 5'(DEPTH - i);
            cycle();
        end
        set_idle();
        sweep_reads();

        // Forwarding of a write to the port reading the same register.
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
        cycle();
        set_idle(); rd_addr[0] = 5'd5;
        cycle();

        // Issue reg 7 twice (second stalls), then write it to clear busy.
        issue = 1'b1; ia = 5'd7; rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
        cycle();
        cycle();
        issue = 1'b0; we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
        cycle();
        we = 1'b0;
        cycle();

        // Issue to register 0 is ignored.
        issue = 1'b1; ia = 5'd0; rd_addr[0] = 5'd0;
        cycle();

        // Same-cycle write and issue of reg 9: data lands, busy stays set.
        issue = 1'b1; ia = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h0000_1234;
        rd_addr[0] = 5'd9; rd_addr[1] = 5'd9;
        cycle();
        set_idle(); rd_addr[0] = 5'd9; rd_addr[1] = 5'd9;
        cycle();

        // Bulk clear with blocked writes and ignored re-trigger attempts.
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        edges = 1;
        we = 1'b1; wa = 5'd3; wd = 32'hFFFF_FFFF;
        while (!cdone_byp && edges < 100) begin
            issue = 1'($urandom_range(0, 1)); ia = 5'($urandom);
            clr = 1'($urandom_range(0, 1));
            rd_addr[0] = 5'd3; rd_addr[1] = 5'($urandom);
            cycle();
            edges++;
        end
        check("clear_latency", 64'(edges), 64'(CLR_LAT));
        set_idle();
        cycle();
        sweep_reads();

        // Reset in the middle of a clear aborts it with no done pulse.
        for (int i = 1; i < DEPTH; i++) begin
            we = 1'b1; wa = 5'(i); wd = $urandom;
            cycle();
        end
        set_idle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        sweep_reads();
        for (int i = 0; i < 8; i++) cycle();

        // Randomized traffic with occasional clears and resets.
        for (int n = 0; n < 1500; n++) begin
            we    = 1'($urandom_range(0, 1));
            wa    = 5'($urandom);
            wd    = $urandom;
            issue = 1'($urandom_range(0, 1));
            ia    = 5'($urandom);
            clr   = ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 399) != 0);
            rd_addr[0] = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            rd_addr[1] = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom);
            cycle();
        end
        reset = 1'b1;
        set_idle();
        cycle();

        chk_on = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter: N, default 32, data word width in bits.
REQ-002 Parameter: ADDR, default 5, address width; depth is 2**ADDR registers.
REQ-003 Parameter: NRD, default 2, number of read ports (legal 1..4).
REQ-004 Parameter: BYPASS, default 1, enables write-to-read forwarding when 1.
REQ-005 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-006 Port: reset  in  1  synchronous, active-low reset.
REQ-007 Port: Reg_Write_i  in  1  writeback enable.
REQ-008 Port: Write_Register_i  in  ADDR  writeback address.
REQ-009 Port: Write_Data_i  in  N  writeback data.
REQ-010 Port: Read_Register_i  in  NRD x ADDR  read addresses, packed, port k at bits [k*ADDR +: ADDR].
REQ-011 Port: Read_Data_o  out  NRD x N  read data, packed the same way.
REQ-012 Port: Read_Busy_o  out  NRD  per-port scoreboard busy flag for the addressed register.
REQ-013 Port: Issue_i  in  1  request to mark a destination register pending.
REQ-014 Port: Issue_Register_i  in  ADDR  destination being issued.
REQ-015 Port: Issue_Stall_o  out  1  issue refused this cycle.
REQ-016 Port: Clear_i  in  1  one-cycle pulse that starts a bulk clear.
REQ-017 Port: Clear_Busy_o  out  1  clear engine is running.
REQ-018 Port: Clear_Done_o  out  1  one-cycle pulse on clear completion.

Function
REQ-019 Register 0 SHALL read as zero; writes and issues to address 0 are ignored.
REQ-020 Reads SHALL be combinational (asynchronous) from the array on every port independently.
REQ-021 With BYPASS=1, a read of address A≠0 while Reg_Write_i=1 and Write_Register_i=A SHALL return Write_Data_i in the same cycle and Read_Busy_o=0 for that port; with BYPASS=0 it returns the stored value and stored busy bit.
REQ-022 A write SHALL update the register and clear its busy bit at the next rising edge.
REQ-023 Scoreboard: Issue_i=1 to A≠0 with busy[A]=0 SHALL set busy[A] at the next edge.
REQ-024 Issue_Stall_o SHALL be combinational: 1 when Issue_i=1 and (busy[Issue_Register_i]=1 or Clear_Busy_o=1); a stalled issue has no effect.
REQ-025 Same-cycle write and non-stalled issue to the same A: data is written and busy[A] ends set (issue wins).
REQ-026 Clear FSM states IDLE, CLEAR, DONE; IDLE->CLEAR on Clear_i=1, which also zeroes all busy bits at that edge.
REQ-027 In CLEAR, an ADDR-bit counter starting at 0 SHALL zero one register per cycle; after address 2**ADDR-1 the FSM goes to DONE; DONE lasts one cycle, asserts Clear_Done_o, then returns to IDLE.
REQ-028 Clear_Busy_o SHALL be 1 in CLEAR and DONE; total clear latency from Clear_i edge to Clear_Done_o is 2**ADDR+1 cycles.
REQ-029 While Clear_Busy_o=1, writes SHALL be ignored, issues stalled, Clear_i ignored, and bypass disabled.
REQ-030 Clear_i in DONE or while already in CLEAR SHALL be ignored (no restart).

Reset
REQ-031 reset=0 at a rising edge SHALL zero all registers, all busy bits, the clear counter, and return the FSM to IDLE, overriding any simultaneous write, issue or clear.
REQ-032 After reset, Read_Data_o=0, Read_Busy_o=0, Clear_Busy_o=0, Clear_Done_o=0, Issue_Stall_o=Issue_i&0 (i.e. 0).
REQ-033 Reset asserted mid-clear SHALL abort the clear; no Clear_Done_o pulse is produced.

Structure
REQ-034 Shared package regfile_pkg SHALL hold the clear FSM state enum and the default N/ADDR/NRD constants.
REQ-035 The clear engine SHALL be a sub-module regfile_clear_fsm (FSM, counter, busy/done outputs); array, ports and scoreboard stay in regfile_sb.

Verification
REQ-036 Write random values to regs 1..31 with Reg_Write_i=1, read ports 0/1 sweeping ascending/descending -> each reads its written value, reg 0 reads 0.
REQ-037 Write 0xDEADBEEF to reg 5 while port 0 reads 5 -> BYPASS=1: 0xDEADBEEF same cycle; BYPASS=0: old value until after edge.
REQ-038 Issue reg 7, then issue reg 7 again -> second cycle Issue_Stall_o=1, Read_Busy_o=1 on port reading 7; write reg 7 -> busy clears next edge.
REQ-039 Same cycle write reg 9=0x1234 and issue reg 9 -> reg 9 reads 0x1234, busy[9]=1.
REQ-040 Fill registers, pulse Clear_i, attempt write 0xFFFFFFFF to reg 3 during clear -> Clear_Done_o exactly 33 cycles after pulse edge, all regs 0, busy all 0.
REQ-041 Start clear, assert reset=0 at cycle 10 -> FSM IDLE, Clear_Busy_o=0, no Clear_Done_o, all regs 0.
